alu_op_sequencer: RTL

- Upstream control stage for the 8-op ALU (OP 3b, signed A/B, Result, ONZ flags).
- Accepts one instruction at a time over a valid/ready handshake and reads operands from an internal register file.
- Drives OP/A/B to the combinational ALU, captures Result/ONZ, writes back to the register file and keeps a sticky flag register.
- Forms the datapath controller of the lab processor.

---
 rtl/alu_seq_pkg.sv | 29 ++
 rtl/seq_regfile.sv | 44 ++++
 rtl/alu_op_sequencer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared opcode constants, FSM state and instruction layout for the ALU op sequencer.
package alu_seq_pkg;

  localparam logic [3:0] OPC_ADD  = 4'b0000;
  localparam logic [3:0] OPC_SUB  = 4'b0001;
  localparam logic [3:0] OPC_AND  = 4'b0010;
  localparam logic [3:0] OPC_OR   = 4'b0011;
  localparam logic [3:0] OPC_XOR  = 4'b0100;
  localparam logic [3:0] OPC_INC  = 4'b0101;
  localparam logic [3:0] OPC_MOVA = 4'b0110;
  localparam logic [3:0] OPC_MOVB = 4'b0111;
  localparam logic [3:0] OPC_LDI  = 4'b1000;
  localparam logic [3:0] OPC_NOP  = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    WB    = 2'd3
  } state_t;

  typedef struct packed {
    logic [3:0] opc;
    logic [2:0] rd;
    logic [2:0] ra;
    logic [2:0] rb;
  } instr_t;

endpackage

// File: rtl/seq_regfile.sv
// 8xN register file, two combinational read ports, one write port, sync active-low reset.
// Optional debug read port under SEQ_DBG_PORT_EN.
module seq_regfile
  import alu_seq_pkg::*;
#(
  parameter int unsigned N    = 8,
  parameter int unsigned NREG = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [2:0]   raddr_a,
  output logic [N-1:0] rdata_a,
  input  logic [2:0]   raddr_b,
  output logic [N-1:0] rdata_b,
`ifdef SEQ_DBG_PORT_EN
  input  logic [2:0]   raddr_d,
  output logic [N-1:0] rdata_d,
`endif
  input  logic         we,
  input  logic [2:0]   waddr,
  input  logic [N-1:0] wdata
);

  logic [N-1:0] mem_q [NREG];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata_a = mem_q[raddr_a];
  assign rdata_b = mem_q[raddr_b];

`ifdef SEQ_DBG_PORT_EN
  // Reads the array directly, so a same-cycle write shows up only after the edge.
  assign rdata_d = mem_q[raddr_d];
`endif

endmodule

// File: rtl/alu_op_sequencer.sv
// Four-state IDLE/FETCH/EXEC/WB controller driving the 8-op ALU from an internal register file.
// Define SEQ_DBG_PORT_EN to add the dbg_addr/dbg_data register read port.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned N    = 8,
  parameter int unsigned NREG = 8,
  parameter int unsigned IW   = 13
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [IW-1:0] instr,
  output logic [2:0]    alu_op,
  output logic [N-1:0]  alu_a,
  output logic [N-1:0]  alu_b,
  input  logic [N-1:0]  alu_result,
  input  logic [2:0]    alu_onz,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  wb_data,
  output logic [2:0]    flags,
`ifdef SEQ_DBG_PORT_EN
  input  logic [2:0]    dbg_addr,
  output logic [N-1:0]  dbg_data,
`endif
  output logic          illegal
);

  state_t       state_q, state_d;
  instr_t       instr_q;
  logic [2:0]   alu_op_q;
  logic [N-1:0] alu_a_q, alu_b_q;
  logic [N-1:0] hold_q;
  logic [2:0]   onz_q;
  logic [2:0]   flags_q;
  logic [N-1:0] wb_data_q;
  logic         done_q, illegal_q;

  logic [N-1:0] rdata_a, rdata_b, imm_ext;
  logic         is_alu, is_ldi, is_nop, is_illegal, rf_we;

  assign is_alu     = ~instr_q.opc[3];
  assign is_ldi     = (instr_q.opc == OPC_LDI);
  assign is_nop     = (instr_q.opc == OPC_NOP);
  assign is_illegal = instr_q.opc[3] & ~is_ldi & ~is_nop;
  assign imm_ext    = {{(N-6){instr_q.ra[2]}}, instr_q.ra, instr_q.rb};
  assign rf_we      = (state_q == WB) & (is_alu | is_ldi);

  seq_regfile #(
    .N    (N),
    .NREG (NREG)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .raddr_a (instr_q.ra),
    .rdata_a (rdata_a),
    .raddr_b (instr_q.rb),
    .rdata_b (rdata_b),
`ifdef SEQ_DBG_PORT_EN
    .raddr_d (dbg_addr),
    .rdata_d (dbg_data),
`endif
    .we      (rf_we),
    .waddr   (instr_q.rd),
    .wdata   (hold_q)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (instr_valid) state_d = FETCH;
      FETCH: state_d = EXEC;
      EXEC:  state_d = WB;
      WB:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      instr_q   <= '0;
      alu_op_q  <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      hold_q    <= '0;
      onz_q     <= '0;
      flags_q   <= '0;
      wb_data_q <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (instr_valid) instr_q <= instr;
        end
        FETCH: begin
          alu_a_q <= rdata_a;
          alu_b_q <= rdata_b;
          if (is_alu) alu_op_q <= instr_q.opc[2:0];
        end
        EXEC: begin
          if (is_alu) begin
            hold_q <= alu_result;
            onz_q  <= alu_onz;
          end else if (is_ldi) begin
            hold_q <= imm_ext;
          end
        end
        WB: begin
          done_q    <= 1'b1;
          illegal_q <= is_illegal;
          wb_data_q <= rf_we ? hold_q : '0;
          if (is_alu) flags_q <= onz_q;
        end
        default: ;
      endcase
    end
  end

  assign instr_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign alu_op      = alu_op_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign done        = done_q;
  assign illegal     = illegal_q;
  assign wb_data     = wb_data_q;
  assign flags       = flags_q;

endmodule
